// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=3 rate-1/2 encoder and the Viterbi decoder.
// The decoder's branch metrics and traceback must use these same generators.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic {
    DATA = 1'b0,
    TAIL = 1'b1
  } enc_state_t;

  // Parity of the window bits selected by a generator
  function automatic logic parity(input logic [K-1:0] w, input logic [K-1:0] g);
    return ^(w & g);
  endfunction

endpackage

// File: rtl/conv_encoder_k3_if.sv
// Bit-in / symbol-out handshake bundle of the convolutional encoder.
interface conv_encoder_k3_if;
  import viterbi_pkg::*;

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  sym_t out_pair;
  logic out_last;

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_pair, out_last
  );

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_pair, out_last
  );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational window-to-symbol mapper: w = {b, s}, out[i] = parity(w & Gi).
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic         b,
  input  logic [K-2:0] s,
  output sym_t         sym
);

  logic [K-1:0] w_s;

  assign w_s = {b, s};
  assign sym = {parity(w_s, G1), parity(w_s, G0)};

endmodule

// File: rtl/conv_encoder_k3.sv
// Framed rate-1/2 K=3 convolutional encoder; every frame is flushed with K-1
// zero tail bits so the decoder trellis terminates in state 0.
module conv_encoder_k3
  import viterbi_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  conv_encoder_k3_if.slave  bus,
  output logic              busy
);

  localparam int TAIL_W = (K > 2) ? $clog2(K - 1) : 1;

  enc_state_t        state_r;
  logic [K-2:0]      s_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TAIL_W-1:0] tail_cnt_r;
  sym_t              out_pair_r;
  logic              out_valid_r;
  logic              out_last_r;

  logic         load_ok_s;
  logic         accept_s;
  logic         b_s;
  logic [K-2:0] next_s_s;
  sym_t         sym_s;

  assign load_ok_s = !out_valid_r || bus.out_ready;
  assign accept_s  = (state_r == DATA) && bus.in_valid && load_ok_s;
  assign b_s       = (state_r == DATA) ? bus.in_bit : 1'b0;
  assign next_s_s  = {b_s, s_r[K-2:1]};

  conv_enc_core u_core (
    .b   (b_s),
    .s   (s_r),
    .sym (sym_s)
  );

  // Frame FSM, bit/tail counters, shift state and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= DATA;
      s_r         <= {(K-1){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      tail_cnt_r  <= {TAIL_W{1'b0}};
      out_pair_r  <= 2'b00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        DATA: begin
          if (accept_s) begin
            out_pair_r  <= sym_s;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            s_r         <= next_s_s;
            if (cnt_r == CNT_W'(FRAME_LEN - 1)) begin
              cnt_r      <= {CNT_W{1'b0}};
              tail_cnt_r <= {TAIL_W{1'b0}};
              state_r    <= TAIL;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        TAIL: begin
          if (load_ok_s) begin
            out_pair_r  <= sym_s;
            out_valid_r <= 1'b1;
            // Final flush symbol returns the trellis to state 0
            if (tail_cnt_r == TAIL_W'(K - 2)) begin
              out_last_r <= 1'b1;
              s_r        <= {(K-1){1'b0}};
              state_r    <= DATA;
            end else begin
              out_last_r <= 1'b0;
              s_r        <= next_s_s;
              tail_cnt_r <= tail_cnt_r + TAIL_W'(1);
            end
          end
        end
        default: begin
          state_r <= DATA;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == DATA) && load_ok_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pair  = out_pair_r;
  assign bus.out_last  = out_last_r;
  assign busy          = (cnt_r != {CNT_W{1'b0}}) || (state_r == TAIL);

endmodule
